// File: rtl/jag_div_pkg.sv
// Shared types and constants for the jag_divider iterative divider.
package jag_div_pkg;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] DIV_ITER_NORMAL = 6'd32;
  localparam logic [CNT_W-1:0] DIV_ITER_OFFSET = 6'd48;

  typedef enum logic {IDLE, RUN} div_state_e;
endpackage

// File: rtl/jag_divider_if.sv
// Start/busy/done handshake, operand and result bundle for jag_divider.
interface jag_divider_if;
  logic        start;
  logic        offset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output start, offset, dividend, divisor,
    input  busy, done, div0, quotient, remainder
  );

  modport slave (
    input  start, offset, dividend, divisor,
    output busy, done, div0, quotient, remainder
  );
endinterface

// File: rtl/jag_div_step.sv
// One restoring division step: compare the partial remainder with the divisor and subtract on success.
module jag_div_step (
  input  logic [32:0] part_rem,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        qbit
);
  assign qbit = (part_rem >= {1'b0, divisor});
  // Result is always below the divisor, so the low 32 bits of the difference are exact.
  assign rem_next = qbit ? (part_rem[31:0] - divisor) : part_rem[31:0];
endmodule

// File: rtl/jag_divider.sv
// Iterative unsigned 32-bit divider, one quotient bit per clock.
// Define JAG_DIV_OFFSET_EN to enable 16.16 offset mode (dividend pre-scaled by 2^16, 48 iterations).
module jag_divider
  import jag_div_pkg::*;
(
  input logic          sys_clk,
  input logic          resetl,
  jag_divider_if.slave bus
);
`ifdef JAG_DIV_OFFSET_EN
  localparam int DVD_W = 48;
`else
  localparam int DVD_W = 32;
`endif

  div_state_e       state;
  logic [DVD_W-1:0] dvd_sr;
  logic [31:0]      dvs_reg;
  logic [31:0]      rem_acc;
  logic [31:0]      quo_sr;
  logic [CNT_W-1:0] cnt;
  logic             zero_pend;

  logic             accept;
  logic [CNT_W-1:0] iter_n;
  logic [DVD_W-1:0] dvd_load;
  logic [32:0]      part_rem;
  logic [31:0]      rem_next;
  logic             qbit;

  assign accept = bus.start && !bus.busy;

`ifdef JAG_DIV_OFFSET_EN
  // Dividend is left-aligned in both modes; offset mode just runs 16 extra iterations on zeros.
  assign iter_n   = bus.offset ? DIV_ITER_OFFSET : DIV_ITER_NORMAL;
  assign dvd_load = {bus.dividend, 16'h0000};
`else
  logic unused_offset;
  assign unused_offset = bus.offset;
  assign iter_n        = DIV_ITER_NORMAL;
  assign dvd_load      = bus.dividend;
`endif

  assign part_rem = {rem_acc, dvd_sr[DVD_W-1]};

  jag_div_step u_step (
    .part_rem (part_rem),
    .divisor  (dvs_reg),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.div0      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      zero_pend     <= 1'b0;
      cnt           <= '0;
      dvd_sr        <= '0;
      dvs_reg       <= '0;
      rem_acc       <= '0;
      quo_sr        <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (zero_pend) begin
            // Divide-by-zero completes one cycle after acceptance; rem_acc holds the dividend.
            zero_pend     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.div0      <= 1'b1;
            bus.quotient  <= 32'hFFFF_FFFF;
            bus.remainder <= rem_acc;
          end else if (accept) begin
            bus.busy      <= 1'b1;
            bus.div0      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            dvs_reg       <= bus.divisor;
            dvd_sr        <= dvd_load;
            quo_sr        <= '0;
            cnt           <= iter_n;
            if (bus.divisor == 32'd0) begin
              zero_pend <= 1'b1;
              rem_acc   <= bus.dividend;
            end else begin
              rem_acc <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          rem_acc <= rem_next;
          quo_sr  <= {quo_sr[30:0], qbit};
          dvd_sr  <= {dvd_sr[DVD_W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == 6'd1) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= {quo_sr[30:0], qbit};
            bus.remainder <= rem_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jag_divider.sv
// Self-checking bench for jag_divider: directed cases, divide-by-zero, ignored start, mid-run reset,
// back-to-back operation and randomized divisions against an arithmetic reference model.
module tb_jag_divider;
`ifdef JAG_DIV_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 sys_clk = ~sys_clk;

  jag_divider_if bus ();

  jag_divider dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus)
  );

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic off,
                                  output logic [31:0] q, output logic [31:0] r, output logic z,
                                  output int lat);
    logic [63:0] num;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
      return;
    end
    num = (off && OFF_EN) ? {16'h0, a, 16'h0} : {32'h0, a};
    q   = 32'(num / {32'h0, b});
    r   = 32'(num % {32'h0, b});
    z   = 1'b0;
    lat = (off && OFF_EN) ? 48 : 32;
  endfunction

  // Runs one division; lat is the number of edges after acceptance until done is seen (-1 on timeout).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic off,
                         output logic [31:0] q, output logic [31:0] r, output logic z,
                         output int lat, output logic busy1, output logic div0_1,
                         output logic pulse_ok);
    @(negedge sys_clk);
    bus.start = 1'b1; bus.offset = off; bus.dividend = a; bus.divisor = b;
    @(posedge sys_clk); #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom; bus.offset = $urandom_range(0, 1);
    @(negedge sys_clk);
    busy1 = bus.busy; div0_1 = bus.div0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      if (bus.done) begin lat = c; break; end
    end
    q = bus.quotient; r = bus.remainder; z = bus.div0;
    @(posedge sys_clk); @(negedge sys_clk);
    pulse_ok = !bus.done;
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    #12;
    tests_run++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b div0=%b q=%h r=%h, required all zero",
               bus.busy, bus.done, bus.div0, bus.quotient, bus.remainder);
    end
    @(negedge sys_clk); resetl = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] q, r; logic z, b1, d1, p; int lat;
    logic [31:0] eq, er; int el;

    run_div(32'd100, 32'd7, 1'b0, q, r, z, lat, b1, d1, p);
    tests_run++;
    if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      tests_failed++; $display("FAIL div_100_7: q=%0d r=%0d div0=%b, required 14 2 0", q, r, z);
    end
    tests_run++;
    if (lat !== 32 || b1 !== 1'b1 || p !== 1'b1) begin
      tests_failed++; $display("FAIL timing_100_7: lat=%0d busy=%b single_pulse=%b, required 32 1 1", lat, b1, p);
    end

    run_div(32'd1, 32'd2, 1'b1, q, r, z, lat, b1, d1, p);
    eq = OFF_EN ? 32'h0000_8000 : 32'd0;
    er = OFF_EN ? 32'd0 : 32'd1;
    el = OFF_EN ? 48 : 32;
    tests_run++;
    if (q !== eq || r !== er || lat !== el) begin
      tests_failed++; $display("FAIL offset_1_2: q=%h r=%h lat=%0d, required %h %h %0d", q, r, lat, eq, er, el);
    end

    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, z, lat, b1, d1, p);
    tests_run++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd0 || lat !== 32) begin
      tests_failed++; $display("FAIL max_div_1: q=%h r=%h lat=%0d, required ffffffff 0 32", q, r, lat);
    end

    run_div(32'd5, 32'hFFFF_FFFF, 1'b0, q, r, z, lat, b1, d1, p);
    tests_run++;
    if (q !== 32'd0 || r !== 32'd5 || lat !== 32) begin
      tests_failed++; $display("FAIL 5_div_max: q=%h r=%h lat=%0d, required 0 5 32", q, r, lat);
    end
  endtask

  task automatic test_div0();
    logic [31:0] q, r; logic z, b1, d1, p; int lat;
    run_div(32'd1234, 32'd0, 1'b0, q, r, z, lat, b1, d1, p);
    tests_run++;
    if (z !== 1'b1 || q !== 32'hFFFF_FFFF || r !== 32'd1234) begin
      tests_failed++; $display("FAIL div0_result: div0=%b q=%h r=%0d, required 1 ffffffff 1234", z, q, r);
    end
    tests_run++;
    if (lat !== 1 || b1 !== 1'b1 || p !== 1'b1) begin
      tests_failed++; $display("FAIL div0_timing: lat=%0d busy=%b single_pulse=%b, required 1 1 1", lat, b1, p);
    end
    tests_run++;
    if (bus.div0 !== 1'b1) begin
      tests_failed++; $display("FAIL div0_hold: div0=%b, required 1", bus.div0);
    end
    run_div(32'd9, 32'd3, 1'b0, q, r, z, lat, b1, d1, p);
    tests_run++;
    if (d1 !== 1'b0 || q !== 32'd3 || r !== 32'd0 || z !== 1'b0) begin
      tests_failed++; $display("FAIL div0_clear: div0_after_start=%b q=%0d r=%0d, required 0 3 0", d1, q, r);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.offset = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd10;
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 6; c <= 100; c++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      if (bus.done) begin lat = c; break; end
    end
    tests_run++;
    if (bus.quotient !== 32'd100 || bus.remainder !== 32'd0 || lat !== 32) begin
      tests_failed++;
      $display("FAIL ignore_busy: q=%0d r=%0d lat=%0d, required 100 0 32", bus.quotient, bus.remainder, lat);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic z, b1, d1, p; int lat; int done_seen;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.offset = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd10;
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge sys_clk);
    @(negedge sys_clk);
    resetl = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b div0=%b q=%h r=%h, required all zero",
               bus.busy, bus.done, bus.div0, bus.quotient, bus.remainder);
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (bus.done) done_seen++;
    end
    resetl = 1'b1;
    repeat (40) begin
      @(negedge sys_clk);
      if (bus.done || bus.busy) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++; $display("FAIL reset_no_done: activity_cycles=%0d, required 0", done_seen);
    end
    run_div(32'd9, 32'd3, 1'b0, q, r, z, lat, b1, d1, p);
    tests_run++;
    if (q !== 32'd3 || r !== 32'd0 || lat !== 32) begin
      tests_failed++; $display("FAIL after_reset_9_3: q=%0d r=%0d lat=%0d, required 3 0 32", q, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] da[4], db[4];
    logic [31:0] eq, er; logic ez; int el; int lat;
    for (int i = 0; i < 4; i++) begin
      da[i] = $urandom;
      db[i] = $urandom_range(1, 60000);
    end
    @(negedge sys_clk);
    bus.start = 1'b1; bus.offset = 1'b0; bus.dividend = da[0]; bus.divisor = db[0];
    @(posedge sys_clk);
    for (int k = 0; k < 4; k++) begin
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
        @(posedge sys_clk); @(negedge sys_clk);
        if (bus.done) begin lat = c; break; end
      end
      ref_div(da[k], db[k], 1'b0, eq, er, ez, el);
      tests_run++;
      if (bus.quotient !== eq || bus.remainder !== er || lat !== el) begin
        tests_failed++;
        $display("FAIL b2b_%0d: q=%h r=%h lat=%0d, required %h %h %0d", k, bus.quotient, bus.remainder, lat, eq, er, el);
      end
      if (k < 3) begin
        bus.dividend = da[k+1]; bus.divisor = db[k+1];
        @(posedge sys_clk); @(negedge sys_clk);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          tests_failed++; $display("FAIL b2b_gap_%0d: busy=%b done=%b, required 1 0", k, bus.busy, bus.done);
        end
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er; logic off, z, ez, b1, d1, p; int lat, el;
    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      off = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 255);
        3:       b = a;
        default: b = $urandom;
      endcase
      ref_div(a, b, off, eq, er, ez, el);
      run_div(a, b, off, q, r, z, lat, b1, d1, p);
      tests_run++;
      if (q !== eq || r !== er || z !== ez || lat !== el || p !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_%0d: %h/%h off=%b got q=%h r=%h z=%b lat=%0d pulse=%b, required %h %h %b %0d 1",
                 n, a, b, off, q, r, z, lat, p, eq, er, ez, el);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.offset = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_directed();
    test_div0();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
